// File: rtl/control_step_sequencer_if.sv
// Bus between the instruction decoder / datapath and the T-step sequencer.
// The master side drives sequencing requests and receives the step controls;
// the slave side is the sequencer itself.
interface control_step_sequencer_if #(
    parameter int STEP_W    = 4,
    parameter int MAX_STEPS = 12
);
    logic                 run;
    logic                 halt;
    logic                 mem_ready;
    logic                 stall;
    logic [STEP_W-1:0]    exec_steps;
    logic                 pco;
    logic                 mari;
    logic                 incpc;
    logic                 mem_read;
    logic                 mdri;
    logic                 mdro;
    logic                 iri;
    logic [STEP_W-1:0]    step;
    logic [MAX_STEPS-1:0] step_oh;
    logic                 busy;
    logic                 instr_done;
    logic                 halted;

    modport master (
        output run, halt, mem_ready, stall, exec_steps,
        input  pco, mari, incpc, mem_read, mdri, mdro, iri,
        input  step, step_oh, busy, instr_done, halted
    );

    modport slave (
        input  run, halt, mem_ready, stall, exec_steps,
        output pco, mari, incpc, mem_read, mdri, mdro, iri,
        output step, step_oh, busy, instr_done, halted
    );
endinterface

// File: rtl/control_step_sequencer.sv
// T-step sequencer: runs fetch steps T0-T2 itself, then counts the execute
// steps T3..T(2+count) supplied by the decoder. Supports memory wait in T1,
// execute stalls, halt at instruction end and resume via run.
module control_step_sequencer #(
    parameter int STEP_W    = 4,
    parameter int MAX_STEPS = 12,
    parameter int MEM_WAIT  = 0
) (
    input  logic                     clock,
    input  logic                     clear,
    control_step_sequencer_if.slave  bus
);
    // Wide enough to hold MEM_WAIT; the counter saturates there.
    localparam int WAIT_W = $clog2(MEM_WAIT + 1) + 1;
    localparam logic [STEP_W-1:0]    EXEC_MAX = STEP_W'(MAX_STEPS - 3);
    localparam logic [WAIT_W-1:0]    WAIT_MIN = WAIT_W'(MEM_WAIT);
    localparam logic [MAX_STEPS-1:0] OH_ONE   = MAX_STEPS'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_FETCH2 = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [STEP_W-1:0] exec_step_r, exec_step_s;
    logic [STEP_W-1:0] count_r, count_s;
    logic [WAIT_W-1:0] wait_r, wait_s;
    logic [STEP_W-1:0] clamp_s;
    logic [STEP_W-1:0] last_step_s;
    logic              last_s;

    logic              pco_s, mari_s, incpc_s, mem_read_s, mdri_s, mdro_s, iri_s;
    logic              busy_s, instr_done_s, halted_s;
    logic [STEP_W-1:0] step_s;

    // Clamp keeps 2+count within MAX_STEPS-1, so the step counter cannot wrap.
    always_comb begin
        if (bus.exec_steps > EXEC_MAX) begin
            clamp_s = EXEC_MAX;
        end else begin
            clamp_s = bus.exec_steps;
        end
    end

    assign last_step_s = count_r + STEP_W'(2);
    assign last_s      = (exec_step_r == last_step_s);

    // State, execute-step, latched count and T1 wait counter registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            exec_step_r <= '0;
            count_r     <= '0;
            wait_r      <= '0;
        end else begin
            state_r     <= state_s;
            exec_step_r <= exec_step_s;
            count_r     <= count_s;
            wait_r      <= wait_s;
        end
    end

    // Next-state logic; halt is only looked at when an instruction ends.
    always_comb begin
        state_s     = state_r;
        exec_step_s = exec_step_r;
        count_s     = count_r;
        wait_s      = wait_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) begin
                    state_s = ST_FETCH0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH0: begin
                state_s = ST_FETCH1;
                wait_s  = '0;
            end
            ST_FETCH1: begin
                if (bus.mem_ready && (wait_r == WAIT_MIN)) begin
                    state_s = ST_FETCH2;
                end else if (wait_r != WAIT_MIN) begin
                    wait_s = wait_r + WAIT_W'(1);
                end else begin
                    wait_s = wait_r;
                end
            end
            ST_FETCH2: begin
                count_s = clamp_s;
                if (clamp_s == '0) begin
                    exec_step_s = '0;
                    if (bus.halt) begin
                        state_s = ST_HALTED;
                    end else begin
                        state_s = ST_FETCH0;
                    end
                end else begin
                    exec_step_s = STEP_W'(3);
                    state_s     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.stall) begin
                    exec_step_s = exec_step_r;
                end else if (last_s) begin
                    exec_step_s = '0;
                    if (bus.halt) begin
                        state_s = ST_HALTED;
                    end else begin
                        state_s = ST_FETCH0;
                    end
                end else begin
                    exec_step_s = exec_step_r + STEP_W'(1);
                end
            end
            ST_HALTED: begin
                if (bus.run && !bus.halt) begin
                    state_s = ST_FETCH0;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state; the only input dependence is the
    // zero-count instr_done in T2, where the count is not yet latched.
    always_comb begin
        pco_s        = 1'b0;
        mari_s       = 1'b0;
        incpc_s      = 1'b0;
        mem_read_s   = 1'b0;
        mdri_s       = 1'b0;
        mdro_s       = 1'b0;
        iri_s        = 1'b0;
        busy_s       = 1'b0;
        instr_done_s = 1'b0;
        halted_s     = 1'b0;
        step_s       = '0;
        case (state_r)
            ST_FETCH0: begin
                pco_s   = 1'b1;
                mari_s  = 1'b1;
                incpc_s = 1'b1;
                busy_s  = 1'b1;
                step_s  = STEP_W'(0);
            end
            ST_FETCH1: begin
                mem_read_s = 1'b1;
                mdri_s     = 1'b1;
                busy_s     = 1'b1;
                step_s     = STEP_W'(1);
            end
            ST_FETCH2: begin
                mdro_s       = 1'b1;
                iri_s        = 1'b1;
                busy_s       = 1'b1;
                step_s       = STEP_W'(2);
                instr_done_s = (clamp_s == '0);
            end
            ST_EXEC: begin
                busy_s       = 1'b1;
                step_s       = exec_step_r;
                instr_done_s = last_s;
            end
            ST_HALTED: begin
                halted_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign bus.pco        = pco_s;
    assign bus.mari       = mari_s;
    assign bus.incpc      = incpc_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mdri       = mdri_s;
    assign bus.mdro       = mdro_s;
    assign bus.iri        = iri_s;
    assign bus.busy       = busy_s;
    assign bus.instr_done = instr_done_s;
    assign bus.halted     = halted_s;
    assign bus.step       = step_s;
    assign bus.step_oh    = busy_s ? (OH_ONE << step_s) : '0;
endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer. Two instances (MEM_WAIT 0 and 2)
// share stimulus; a step-numbered behavioural model predicts every output of
// both each cycle, and hand-computed literals pin the key spots.
module tb_control_step_sequencer;
    localparam int SW   = 4;
    localparam int MAXS = 12;

    logic          clock = 1'b0;
    logic          clear;
    logic          run, halt, mem_ready, stall;
    logic [SW-1:0] exec_steps;
    logic          check_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    control_step_sequencer_if #(.STEP_W(SW), .MAX_STEPS(MAXS)) if0 ();
    control_step_sequencer_if #(.STEP_W(SW), .MAX_STEPS(MAXS)) if2 ();

    assign if0.run = run;        assign if2.run = run;
    assign if0.halt = halt;      assign if2.halt = halt;
    assign if0.mem_ready = mem_ready; assign if2.mem_ready = mem_ready;
    assign if0.stall = stall;    assign if2.stall = stall;
    assign if0.exec_steps = exec_steps; assign if2.exec_steps = exec_steps;

    control_step_sequencer #(.STEP_W(SW), .MAX_STEPS(MAXS), .MEM_WAIT(0)) dut0 (
        .clock(clock), .clear(clear), .bus(if0));
    control_step_sequencer #(.STEP_W(SW), .MAX_STEPS(MAXS), .MEM_WAIT(2)) dut2 (
        .clock(clock), .clear(clear), .bus(if2));

    wire [25:0] dv0 = {if0.pco, if0.mari, if0.incpc, if0.mem_read, if0.mdri, if0.mdro,
                       if0.iri, if0.busy, if0.instr_done, if0.halted, if0.step, if0.step_oh};
    wire [25:0] dv2 = {if2.pco, if2.mari, if2.incpc, if2.mem_read, if2.mdri, if2.mdro,
                       if2.iri, if2.busy, if2.instr_done, if2.halted, if2.step, if2.step_oh};

    // Model: per instance, busy/halted flags, current T index, execute count, T1 cycles.
    int m_busy[2], m_halted[2], m_step[2], m_cnt[2], m_wait[2];

    function automatic int clampf(input logic [SW-1:0] e);
        return (int'(e) > MAXS - 3) ? MAXS - 3 : int'(e);
    endfunction

    function automatic int mem_wait_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    function automatic logic [25:0] exp_vec(input int k);
        logic          b, f0, f1, f2, done;
        logic [SW-1:0] st;
        logic [11:0]   oh;
        b    = (m_busy[k] != 0);
        f0   = b && m_step[k] == 0;
        f1   = b && m_step[k] == 1;
        f2   = b && m_step[k] == 2;
        done = b && ((m_step[k] == 2 && clampf(exec_steps) == 0) ||
                     (m_step[k] >= 3 && m_step[k] == 2 + m_cnt[k]));
        st   = b ? SW'(m_step[k]) : 4'd0;
        oh   = b ? (12'b1 << m_step[k]) : 12'd0;
        return {f0, f0, f0, f1, f1, f2, f2, b, done, (m_halted[k] != 0), st, oh};
    endfunction

    // Advance the model on each rising edge from the inputs present at that edge.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            automatic int b = m_busy[k];
            automatic int h = m_halted[k];
            automatic int s = m_step[k];
            automatic int c = m_cnt[k];
            automatic int w = m_wait[k];
            automatic bit fin = 1'b0;
            if (clear) begin
                b = 0; h = 0; s = 0; c = 0; w = 0;
            end else if (b == 0) begin
                if (run && !(h == 1 && halt)) begin b = 1; h = 0; s = 0; end
            end else if (s == 0) begin
                s = 1; w = 0;
            end else if (s == 1) begin
                if (mem_ready && w >= mem_wait_of(k)) s = 2;
                else w = w + 1;
            end else if (s == 2) begin
                c = clampf(exec_steps);
                if (c == 0) fin = 1'b1;
                else s = 3;
            end else if (!stall) begin
                if (s == 2 + c) fin = 1'b1;
                else s = s + 1;
            end
            if (fin) begin
                s = 0;
                if (halt) begin b = 0; h = 1; end
            end
            m_busy[k]   <= b;
            m_halted[k] <= h;
            m_step[k]   <= s;
            m_cnt[k]    <= c;
            m_wait[k]   <= w;
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clock) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                automatic logic [25:0] got = (k == 0) ? dv0 : dv2;
                automatic logic [25:0] exp = exp_vec(k);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL model_dut%0d got=%h exp=%h at %0t", k, got, exp, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; halt = 1'b0; mem_ready = 1'b1;
        stall = 1'b0; exec_steps = 4'd0;
        cyc();
        check_en = 1'b1;
        cyc();
        clear = 1'b0;
        lit("reset_idle", {6'd0, dv0}, 32'd0);

        // 1: clear mid-T1
        run = 1'b1; mem_ready = 1'b0;
        cyc(); run = 1'b0;
        cyc(); lit("t1_mem_read", if0.mem_read, 1);
        clear = 1'b1;
        cyc(); clear = 1'b0;
        lit("t1_clr_dut0", {6'd0, dv0}, 32'd0);
        lit("t1_clr_dut2", {6'd0, dv2}, 32'd0);

        // 2: plain fetch + 3 execute steps
        mem_ready = 1'b1; exec_steps = 4'd3; run = 1'b1;
        cyc(); run = 1'b0;
        lit("t2_pco", {if0.pco, if0.step}, {1'b1, 4'd0});
        cyc(); lit("t2_mdri", {if0.mdri, if0.step}, {1'b1, 4'd1});
        cyc(); lit("t2_iri", {if0.iri, if0.instr_done, if0.step}, {2'b10, 4'd2});
        cyc(); lit("t2_s3", if0.step, 3);
        cyc(); lit("t2_s4", {if0.instr_done, if0.step}, {1'b0, 4'd4});
        cyc(); lit("t2_s5", {if0.instr_done, if0.step, if0.step_oh}, {1'b1, 4'd5, 12'h020});
        cyc(); lit("t2_back0", {if0.pco, if0.instr_done, if0.step}, {2'b10, 4'd0});
        do_clear();

        // 3a: mem_ready low for 4 cycles in T1
        mem_ready = 1'b0; run = 1'b1;
        cyc(); run = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            lit("t3_hold", {if0.mem_read, if0.mdri, if0.step}, {2'b11, 4'd1});
            if (i == 4) mem_ready = 1'b1;
            cyc();
        end
        lit("t3_leave0", if0.step, 2);
        lit("t3_leave2", if2.step, 2);
        do_clear();

        // 3b: MEM_WAIT=2, mem_ready immediately high
        run = 1'b1;
        cyc(); run = 1'b0;
        cyc(); lit("t3_w1", if2.step, 1);
        cyc(); lit("t3_w2", {if2.step, if0.step}, {4'd1, 4'd2});
        cyc(); lit("t3_w3", if2.mem_read, 1);
        cyc(); lit("t3_w_out", {if2.iri, if2.step}, {1'b1, 4'd2});
        do_clear();

        // 4: execute stall
        exec_steps = 4'd2; run = 1'b1;
        cyc(); run = 1'b0;
        cyc(); cyc(); cyc();
        lit("t4_s3a", {if0.instr_done, if0.step}, {1'b0, 4'd3});
        stall = 1'b1;
        cyc(); lit("t4_s3b", {if0.instr_done, if0.step}, {1'b0, 4'd3});
        cyc(); lit("t4_s3c", {if0.instr_done, if0.step}, {1'b0, 4'd3});
        stall = 1'b0;
        cyc(); lit("t4_s4", {if0.instr_done, if0.step}, {1'b1, 4'd4});
        stall = 1'b1;
        cyc(); lit("t4_s4_stall", {if0.instr_done, if0.step}, {1'b1, 4'd4});
        stall = 1'b0;
        cyc(); lit("t4_end", {if0.instr_done, if0.pco, if0.step}, {2'b01, 4'd0});
        do_clear();

        // 5: clamp, then zero count
        exec_steps = 4'd15; run = 1'b1;
        cyc(); run = 1'b0;
        cyc(); cyc();
        for (int s = 3; s <= 11; s++) begin
            cyc();
            lit("t5_clamp_step", {if0.instr_done, if0.step}, {(s == 11), 4'(s)});
        end
        cyc(); lit("t5_wrap0", {if0.busy, if0.step}, {1'b1, 4'd0});
        exec_steps = 4'd0;
        cyc();
        cyc(); lit("t5_zero_t2", {if0.instr_done, if0.iri, if0.step}, {2'b11, 4'd2});
        cyc(); lit("t5_zero_next", {if0.pco, if0.instr_done, if0.step}, {2'b10, 4'd0});
        do_clear();

        // 6: halt and resume
        exec_steps = 4'd4; run = 1'b1;
        cyc(); run = 1'b0;
        cyc(); cyc(); cyc();
        lit("t6_s3", if0.step, 3);
        halt = 1'b1;
        cyc(); cyc(); cyc();
        lit("t6_s6", {if0.instr_done, if0.step}, {1'b1, 4'd6});
        cyc(); lit("t6_halted", {if0.halted, if0.busy, if0.step}, {2'b10, 4'd0});
        run = 1'b1;
        cyc(); lit("t6_run_ign", {if0.halted, if0.busy}, 2'b10);
        run = 1'b0; halt = 1'b0;
        cyc(); lit("t6_still", if0.halted, 1);
        run = 1'b1;
        cyc(); lit("t6_resume", {if0.pco, if0.busy, if0.halted, if0.step}, {3'b110, 4'd0});
        run = 1'b0; exec_steps = 4'd0; halt = 1'b1;
        cyc();
        cyc(); lit("t6_zero_done", if0.instr_done, 1);
        cyc(); lit("t6_zero_halt", {if0.halted, if0.busy}, 2'b10);
        halt = 1'b0;
        repeat (12) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
